// File: rtl/nios_system_sysid_pkg.sv
// Shared definitions for the system-ID checker.
// Contents: FSM state encoding, Avalon address constants for the sysid slave,
// and the default expected ID/timestamp/timeout/recheck values.
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    SysidIdle   = 3'd0,
    SysidIdReq  = 3'd1,
    SysidIdWait = 3'd2,
    SysidTsReq  = 3'd3,
    SysidTsWait = 3'd4,
    SysidFinish = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1579776193;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 255;
  localparam int unsigned DEFAULT_RECHECK_PERIOD     = 50000000;

endpackage

// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read bus between the sysid checker (master) and the sysid slave.
// Signals: avm_address (0 = ID, 1 = timestamp), avm_read, avm_waitrequest,
// avm_readdata[31:0], avm_readdatavalid.
interface nios_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/nios_system_sysid_timeout.sv
// Loadable down-counter with an expiry indication.
// Ports: clk_i, rst_ni (synchronous, active low), load_i/load_val_i reload the
// count, en_i enables decrement, expired_o is high while enabled at zero.
// Loading N-1 makes expired_o fire in the Nth enabled cycle after the load.
module nios_system_sysid_timeout #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// System-ID checker: reads the ID word (address 0) and timestamp word
// (address 1) from the sysid slave after reset or on start_i, compares both
// against expected values and reports the result.
// Ports: clock, reset_n (synchronous, active low), start_i (re-run pulse),
// avm (Avalon-MM read master), busy_o, done_o, pass_o, id_mismatch_o,
// ts_mismatch_o, timeout_o, id_value_o, ts_value_o.
// Build option: define SYSID_CHECKER_PERIODIC_EN to re-run the check after
// RECHECK_PERIOD consecutive idle cycles.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned RECHECK_PERIOD     = DEFAULT_RECHECK_PERIOD
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start_i,
  nios_system_sysid_checker_if.master avm,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic                        id_mismatch_o,
  output logic                        ts_mismatch_o,
  output logic                        timeout_o,
  output logic [31:0]                 id_value_o,
  output logic [31:0]                 ts_value_o
);

  localparam logic [2:0] StIdle   = SysidIdle;
  localparam logic [2:0] StIdReq  = SysidIdReq;
  localparam logic [2:0] StIdWait = SysidIdWait;
  localparam logic [2:0] StTsReq  = SysidTsReq;
  localparam logic [2:0] StTsWait = SysidTsWait;
  localparam logic [2:0] StFinish = SysidFinish;

  logic [2:0]  state_q, state_d;
  logic        arm_q, arm_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_mm_q, id_mm_d;
  logic        ts_mm_q, ts_mm_d;
  logic        to_q, to_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;

  logic tmo_load, tmo_en, tmo_expired;
  logic recheck;
  logic in_req, in_wait, accepted, rdv;

  assign in_req   = (state_q == StIdReq) || (state_q == StTsReq);
  assign in_wait  = (state_q == StIdWait) || (state_q == StTsWait);
  assign accepted = in_req && !avm.avm_waitrequest;
  // Data only counts once the command has been accepted.
  assign rdv      = avm.avm_readdatavalid && (accepted || in_wait);
  assign tmo_en   = in_req || in_wait;

  // Loaded with TIMEOUT_CYCLES-1 so expiry lands in the TIMEOUT_CYCLES-th
  // REQ/WAIT cycle of each read.
  nios_system_sysid_timeout #(
    .Width(16)
  ) u_timeout (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .load_i    (tmo_load),
    .load_val_i(16'(TIMEOUT_CYCLES - 1)),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

`ifdef SYSID_CHECKER_PERIODIC_EN
  nios_system_sysid_timeout #(
    .Width(32)
  ) u_recheck (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .load_i    (state_q != StIdle),
    .load_val_i(32'(RECHECK_PERIOD - 1)),
    .en_i      (state_q == StIdle),
    .expired_o (recheck)
  );
`else
  assign recheck = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    arm_d    = arm_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    id_mm_d  = id_mm_q;
    ts_mm_d  = ts_mm_q;
    to_d     = to_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    tmo_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arm_q || start_i || recheck) begin
          state_d  = StIdReq;
          arm_d    = 1'b0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          id_mm_d  = 1'b0;
          ts_mm_d  = 1'b0;
          to_d     = 1'b0;
          tmo_load = 1'b1;
        end
      end
      StIdReq, StIdWait: begin
        // Valid data wins over a coincident expiry.
        if (rdv) begin
          id_val_d = avm.avm_readdata;
          id_mm_d  = (avm.avm_readdata != EXPECTED_ID);
          state_d  = StTsReq;
          tmo_load = 1'b1;
        end else if (tmo_expired) begin
          to_d    = 1'b1;
          state_d = StFinish;
        end else if (accepted) begin
          state_d = StIdWait;
        end
      end
      StTsReq, StTsWait: begin
        if (rdv) begin
          ts_val_d = avm.avm_readdata;
          ts_mm_d  = (avm.avm_readdata != EXPECTED_TIMESTAMP);
          state_d  = StFinish;
        end else if (tmo_expired) begin
          to_d    = 1'b1;
          state_d = StFinish;
        end else if (accepted) begin
          state_d = StTsWait;
        end
      end
      StFinish: begin
        pass_d  = !(id_mm_q || ts_mm_q || to_q);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      arm_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      id_mm_q  <= 1'b0;
      ts_mm_q  <= 1'b0;
      to_q     <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      id_mm_q  <= id_mm_d;
      ts_mm_q  <= ts_mm_d;
      to_q     <= to_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

  assign avm.avm_read    = in_req;
  assign avm.avm_address = (state_q == StTsReq) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign id_mismatch_o = id_mm_q;
  assign ts_mismatch_o = ts_mm_q;
  assign timeout_o     = to_q;
  assign id_value_o    = id_val_q;
  assign ts_value_o    = ts_val_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for nios_system_sysid_checker: a behavioural Avalon slave with
// configurable stall, read latency and dropped responses, plus a reference
// model predicting the outcome and duration of each check.
module tb_nios_system_sysid_checker;

  localparam int          T      = 8;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1579776193;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, id_mm, ts_mm, tmo;
  logic [31:0] id_value, ts_value;

  nios_system_sysid_checker_if bus_if ();

  nios_system_sysid_checker #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES    (T),
    .RECHECK_PERIOD    (1000)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_i      (start),
    .avm          (bus_if.master),
    .busy_o       (busy),
    .done_o       (done),
    .pass_o       (pass),
    .id_mismatch_o(id_mm),
    .ts_mismatch_o(ts_mm),
    .timeout_o    (tmo),
    .id_value_o   (id_value),
    .ts_value_o   (ts_value)
  );

  always #5 clock = ~clock;

  // Slave configuration.
  logic [31:0] cfg_id = EXP_ID;
  logic [31:0] cfg_ts = EXP_TS;
  int s_id = 0, d_id = 0, s_ts = 0, d_ts = 0;
  bit drop_id = 1'b0, drop_ts = 1'b0;

  // Slave state and observations.
  int   stall_left = 0, pend_cnt = 0, acc_id = 0, acc_ts = 0, stab_err = 0;
  bit   cmd_open = 1'b0, pend = 1'b0, prev_stall = 1'b0;
  logic pend_addr = 1'b0, prev_addr = 1'b0;

  function automatic logic [31:0] word(logic a);
    return a ? cfg_ts : cfg_id;
  endfunction

  initial begin : slave
    int dly;
    bus_if.avm_waitrequest   = 1'b0;
    bus_if.avm_readdatavalid = 1'b0;
    bus_if.avm_readdata      = 32'hdead_beef;
    forever begin
      @(posedge clock);
      #1;
      bus_if.avm_waitrequest   = 1'b0;
      bus_if.avm_readdatavalid = 1'b0;
      bus_if.avm_readdata      = 32'hdead_beef;
      if (!reset_n) begin
        cmd_open   = 1'b0;
        pend       = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (bus_if.avm_read !== 1'b1 || bus_if.avm_address !== prev_addr))
          stab_err++;
        prev_stall = 1'b0;
        if (pend) begin
          if (pend_cnt == 0) begin
            bus_if.avm_readdatavalid = 1'b1;
            bus_if.avm_readdata      = word(pend_addr);
            pend                     = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        if (bus_if.avm_read === 1'b1) begin
          if (!cmd_open) begin
            cmd_open   = 1'b1;
            stall_left = bus_if.avm_address ? s_ts : s_id;
          end
          if (stall_left > 0) begin
            bus_if.avm_waitrequest = 1'b1;
            stall_left--;
            prev_stall = 1'b1;
            prev_addr  = bus_if.avm_address;
          end else begin
            cmd_open = 1'b0;
            if (bus_if.avm_address) acc_ts++;
            else acc_id++;
            if (!(bus_if.avm_address ? drop_ts : drop_id)) begin
              dly = bus_if.avm_address ? d_ts : d_id;
              if (dly == 0) begin
                bus_if.avm_readdatavalid = 1'b1;
                bus_if.avm_readdata      = word(bus_if.avm_address);
              end else begin
                pend      = 1'b1;
                pend_cnt  = dly - 1;
                pend_addr = bus_if.avm_address;
              end
            end
          end
        end else begin
          cmd_open = 1'b0;
        end
      end
    end
  end

  int tests = 0, fails = 0;

  // Reference model state.
  logic [31:0] m_id = '0, m_ts = '0;
  int e_cyc = 0, e_rid = 0, e_rts = 0, base_id = 0, base_ts = 0;
  bit e_to = 1'b0, e_idmm = 1'b0, e_tsmm = 1'b0, e_pass = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A word arrives in time if it shows up within the first T REQ/WAIT cycles;
  // each read spends stall + delay + 1 cycles, a timed-out read spends T.
  task automatic predict();
    bit id_ok, ts_ok;
    id_ok  = !drop_id && (s_id + d_id <= T - 1);
    ts_ok  = !drop_ts && (s_ts + d_ts <= T - 1);
    e_to   = 1'b0;
    e_idmm = 1'b0;
    e_tsmm = 1'b0;
    e_rid  = 1;
    e_rts  = 0;
    if (id_ok) begin
      m_id   = cfg_id;
      e_idmm = (cfg_id != EXP_ID);
      e_cyc  = s_id + d_id + 1;
      e_rts  = 1;
      if (ts_ok) begin
        m_ts   = cfg_ts;
        e_tsmm = (cfg_ts != EXP_TS);
        e_cyc += s_ts + d_ts + 1;
      end else begin
        e_to   = 1'b1;
        e_cyc += T;
      end
    end else begin
      e_to  = 1'b1;
      e_cyc = T;
    end
    e_pass  = !(e_idmm || e_tsmm || e_to);
    base_id = acc_id;
    base_ts = acc_ts;
  endtask

  // Entered at the first negedge after the edge that starts the check.
  task automatic finish_check(input string tag, input int inject_n);
    int n;
    n = 0;
    chk({tag, "/busy_rise"}, busy, 1'b1);
    do begin
      @(negedge clock);
      n++;
      start = 1'b0;
      if (n == inject_n) start = 1'b1;
    end while (busy && n < 200);
    start = 1'b0;
    chk({tag, "/latency"}, n, e_cyc + 1);
    chk({tag, "/done"}, done, 1'b1);
    chk({tag, "/pass"}, pass, e_pass);
    chk({tag, "/id_mismatch"}, id_mm, e_idmm);
    chk({tag, "/ts_mismatch"}, ts_mm, e_tsmm);
    chk({tag, "/timeout"}, tmo, e_to);
    chk({tag, "/id_value"}, id_value, m_id);
    chk({tag, "/ts_value"}, ts_value, m_ts);
    repeat (3) @(negedge clock);
    chk({tag, "/stays_idle"}, busy, 1'b0);
    chk({tag, "/id_reads"}, acc_id - base_id, e_rid);
    chk({tag, "/ts_reads"}, acc_ts - base_ts, e_rts);
    chk({tag, "/stable_stall"}, stab_err, 0);
  endtask

  task automatic run_start(input string tag, input int inject_n);
    predict();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    finish_check(tag, inject_n);
  endtask

  // Called at a negedge; reset is sampled at the following posedge.
  task automatic run_reset(input string tag);
    reset_n = 1'b0;
    @(negedge clock);
    chk({tag, "/rst_read"}, bus_if.avm_read, 1'b0);
    chk({tag, "/rst_addr"}, bus_if.avm_address, 1'b0);
    chk({tag, "/rst_busy"}, busy, 1'b0);
    chk({tag, "/rst_done"}, done, 1'b0);
    chk({tag, "/rst_pass"}, pass, 1'b0);
    chk({tag, "/rst_flags"}, {id_mm, ts_mm, tmo}, 3'b000);
    chk({tag, "/rst_id_value"}, id_value, 32'h0);
    chk({tag, "/rst_ts_value"}, ts_value, 32'h0);
    m_id = '0;
    m_ts = '0;
    predict();
    reset_n = 1'b1;
    @(negedge clock);
    finish_check(tag, -1);
  endtask

  initial begin : main
    int k;
    @(negedge clock);
    run_reset("reset_zero_wait");

    cfg_id = 32'h0000_0005;
    run_start("id_mismatch", -1);
    cfg_id = EXP_ID;

    s_id = 3;
    s_ts = 3;
    run_start("stall3", -1);
    s_id = 0;
    s_ts = 0;

    drop_id = 1'b1;
    run_start("timeout_id", -1);
    drop_id = 1'b0;

    d_id = 2;
    run_start("start_while_busy", 2);
    d_id = 0;
    run_start("start_in_finish", 2);
    run_start("start_after_done", -1);

    // Reach TS_WAIT, then reset.
    d_ts = 4;
    predict();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (acc_ts == base_ts && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("ts_cmd_seen", (k < 20), 1'b1);
    @(negedge clock);
    chk("in_ts_wait", {busy, bus_if.avm_read}, 2'b10);
    run_reset("reset_in_ts_wait");
    d_ts = 0;

    for (int i = 0; i < 20; i++) begin
      cfg_id  = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      cfg_ts  = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      s_id    = $urandom_range(0, 3);
      d_id    = $urandom_range(0, 3);
      s_ts    = $urandom_range(0, 3);
      d_ts    = $urandom_range(0, 3);
      drop_ts = ($urandom_range(0, 5) == 0);
      run_start($sformatf("rand%0d", i), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios_system_sysid_checker.md
Name: nios_system_sysid_checker

Overview:
- Avalon-MM read master directly upstream of the system-ID slave; consumes its 32-bit readdata.
- After reset, and on request, reads ID word (address 0) and timestamp word (address 1), compares both against expected values and reports pass/fail.
- Lets boot logic and LEDs stop on a mismatched FPGA image without CPU involvement.

Parameters:
- EXPECTED_ID, 32'h00000000, required value at address 0.
- EXPECTED_TIMESTAMP, 32'd1579776193, required value at address 1.
- TIMEOUT_CYCLES, 255, maximum cycles from read issue to readdatavalid; range 1..65535.
- RECHECK_PERIOD, 50000000, idle cycles between automatic rechecks; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; re-runs the check when not busy.
- avm_address  out  1  0 = ID, 1 = timestamp.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; tie low for a zero-wait slave.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- busy  out  1  check in progress.
- done  out  1  at least one check has completed since reset.
- pass  out  1  last check: both words matched.
- id_mismatch  out  1  last check: ID word differed.
- ts_mismatch  out  1  last check: timestamp word differed.
- timeout  out  1  last check: aborted by timeout.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state = IDLE, arm = 1.
  - All outputs 0: avm_read, avm_address, busy, done, pass, all flags, id_value, ts_value.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE:
  - Go to ID_REQ if arm = 1 (first cycle after reset) or start = 1; clear arm.
  - On entry to ID_REQ: clear pass and all flags, set busy = 1. done, id_value and ts_value hold their old values.
- ID_REQ / TS_REQ:
  - avm_read = 1, avm_address = 0 / 1.
  - Address and read stay stable while avm_waitrequest = 1.
  - The first cycle with avm_waitrequest = 0 completes the command; next state is ID_WAIT / TS_WAIT and avm_read drops.
- ID_WAIT / TS_WAIT:
  - On avm_readdatavalid = 1: capture avm_readdata into id_value / ts_value.
    - Set id_mismatch if id_value != EXPECTED_ID; set ts_mismatch if ts_value != EXPECTED_TIMESTAMP.
    - Next state: TS_REQ from ID_WAIT, FINISH from TS_WAIT.
  - readdatavalid asserted in the same cycle the command is accepted is captured; the WAIT state is skipped.
- Timeout counter:
  - 16-bit; cleared on entry to each REQ state; increments every cycle in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES before valid data: set timeout, drop avm_read, go to FINISH.
  - A word not yet read keeps its old captured value.
- FINISH (one cycle):
  - pass = ~(id_mismatch | ts_mismatch | timeout); busy = 0; done = 1; return to IDLE.
- Boundaries:
  - start while busy is ignored (no queuing).
  - start in the FINISH cycle is ignored.
  - readdatavalid in IDLE or REQ-while-stalled is ignored.
  - Reset mid-transaction aborts immediately: avm_read low at the next edge, all state reinitialised, check re-runs automatically.
- Latency:
  - Zero-wait slave with readdatavalid coincident with command acceptance: reset release to done = 1 in 4 cycles (ID_REQ, TS_REQ, FINISH, IDLE).

Optional Feature:
- Macro: SYSID_CHECKER_PERIODIC_EN.
- Defined:
  - 32-bit idle counter runs only in IDLE and reloads when leaving IDLE.
  - When it reaches RECHECK_PERIOD, a check starts as if start were pulsed.
  - A failed periodic check leaves pass = 0 until a later check passes.
- Undefined: no periodic counter; checks run only after reset or on start.

Decomposition:
- Package nios_system_sysid_pkg holds:
  - the state enum typedef;
  - address constants SYSID_ADDR_ID = 1'b0 and SYSID_ADDR_TS = 1'b1;
  - the default expected-value constants.
- One sub-module, nios_system_sysid_timeout: loadable down-counter with an expiry pulse. It is reused by the periodic recheck when SYSID_CHECKER_PERIODIC_EN is defined.

Test Plan:
- Zero-wait slave returning 0 / 1579776193: release reset -> done = 1 and pass = 1 at cycle 4; id_value = 0; ts_value = 1579776193.
- Slave returns ID 32'h00000005 -> id_mismatch = 1, ts_mismatch = 0, pass = 0, id_value = 5.
- avm_waitrequest high for 3 cycles on each read -> avm_address and avm_read stable throughout; pass = 1; done after 10 cycles.
- readdatavalid never asserted, TIMEOUT_CYCLES = 8 -> timeout = 1 after 8 cycles in ID_REQ/ID_WAIT; no address-1 read issued; pass = 0.
- Pulse start while busy, then after done -> first pulse ignored; second pulse produces exactly one more ID+TS read pair.
- Assert reset_n low during TS_WAIT -> next edge: avm_read = 0 and outputs cleared; after release, a full check re-runs and passes.
